// File: rtl/gp_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : gp_reg_bank_if
// Description : General-purpose read/write bus between the AXI-Lite slave
//               (master side) and a register bank (slave side). The read and
//               write channels are independent. A request is held high until
//               its one-cycle done pulse is seen.
//               Signals:
//                 write / write_addrs / write_data / write_strobe  (m -> s)
//                 write_done / write_error                         (s -> m)
//                 read / read_addrs                                (m -> s)
//                 read_data / read_done / read_error               (s -> m)
// Revision    : 1.0 - initial release
// ============================================================================
interface gp_reg_bank_if #(
    parameter int GP_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
);
    logic                      write;
    logic [GP_ADDR_WIDTH-1:0]  write_addrs;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strobe;
    logic                      write_done;
    logic                      write_error;
    logic                      read;
    logic [GP_ADDR_WIDTH-1:0]  read_addrs;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      read_done;
    logic                      read_error;

    modport master (
        output write, write_addrs, write_data, write_strobe, read, read_addrs,
        input  write_done, write_error, read_data, read_done, read_error
    );

    modport slave (
        input  write, write_addrs, write_data, write_strobe, read, read_addrs,
        output write_done, write_error, read_data, read_done, read_error
    );
endinterface
`default_nettype wire

// File: rtl/gp_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : gp_reg_bank
// Description : Register bank behind the GP read/write bus. Holds ID, two
//               scratch words, CTRL (EN, CLR pulse, WAIT), a free-running
//               COUNT and a saturating ERRCNT. Each channel answers after
//               CTRL.WAIT wait states with a one-cycle done/error pulse.
//               Ports:
//                 s_axi_aclk : clock
//                 rst        : synchronous active-high reset
//                 bus        : gp_reg_bank_if slave modport
// Revision    : 1.0 - initial release
// ============================================================================
module gp_reg_bank #(
    parameter int          GP_ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] ID_VALUE      = 32'hA11E0001,
    parameter logic [3:0]  RESET_WAIT    = 4'd0
) (
    input  wire logic      s_axi_aclk,
    input  wire logic      rst,
    gp_reg_bank_if.slave   bus
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_IDX_W  = GP_ADDR_WIDTH - 2;

    localparam logic [c_IDX_W-1:0] c_IDX_ID     = c_IDX_W'(0);
    localparam logic [c_IDX_W-1:0] c_IDX_SCR0   = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_SCR1   = c_IDX_W'(2);
    localparam logic [c_IDX_W-1:0] c_IDX_CTRL   = c_IDX_W'(3);
    localparam logic [c_IDX_W-1:0] c_IDX_COUNT  = c_IDX_W'(4);
    localparam logic [c_IDX_W-1:0] c_IDX_ERRCNT = c_IDX_W'(5);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Register contents
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] scratch0_q;
    logic [DATA_WIDTH-1:0] scratch1_q;
    logic                  en_q;
    logic [3:0]            wait_q;
    logic [31:0]           count_q;
    logic [15:0]           errcnt_q;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [c_STRB_W-1:0]   strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < c_STRB_W; b++) begin
            if (strb[b]) begin
                r[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    state_t                    wr_state_q, wr_state_d;
    logic [3:0]                wr_cnt_q, wr_cnt_d;
    logic [GP_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [c_STRB_W-1:0]       wr_strb_q, wr_strb_d;
    logic                      wr_err_q;

    logic                      w_wr_fire;
    logic                      w_wr_err;
    logic                      w_wr_commit;
    logic [c_IDX_W-1:0]        w_wr_idx;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        case (wr_state_q)
            S_IDLE: begin
                if (bus.write) begin
                    wr_addr_d  = bus.write_addrs;
                    wr_data_d  = bus.write_data;
                    wr_strb_d  = bus.write_strobe;
                    wr_cnt_d   = wait_q;
                    wr_state_d = (wait_q == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Leaving at count 1 makes the total latency WAIT+1 cycles.
                wr_cnt_d = wr_cnt_q - 4'd1;
                if (wr_cnt_q <= 4'd1) begin
                    wr_state_d = S_RESP;
                end
            end
            S_RESP:  wr_state_d = S_IDLE;
            default: wr_state_d = S_IDLE;
        endcase
    end

    // The *_d copies equal the live bus fields when going IDLE->RESP
    // directly, and the latched fields otherwise, so decode always uses them.
    assign w_wr_fire   = (wr_state_d == S_RESP) && (wr_state_q != S_RESP);
    assign w_wr_idx    = wr_addr_d[GP_ADDR_WIDTH-1:2];
    assign w_wr_err    = (wr_addr_d[1:0] != 2'b00) || (w_wr_idx > c_IDX_ERRCNT) ||
                         (w_wr_idx == c_IDX_ID) || (w_wr_idx == c_IDX_COUNT) ||
                         (w_wr_idx == c_IDX_ERRCNT);
    assign w_wr_commit = w_wr_fire && !w_wr_err;

    always_ff @(posedge s_axi_aclk) begin
        if (rst) begin
            wr_state_q <= S_IDLE;
            wr_cnt_q   <= 4'd0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            wr_err_q   <= w_wr_fire && w_wr_err;
        end
    end

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    state_t                    rd_state_q, rd_state_d;
    logic [3:0]                rd_cnt_q, rd_cnt_d;
    logic [GP_ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                      rd_err_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;

    logic                      w_rd_fire;
    logic                      w_rd_err;
    logic [c_IDX_W-1:0]        w_rd_idx;
    logic [DATA_WIDTH-1:0]     w_rd_val;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        case (rd_state_q)
            S_IDLE: begin
                if (bus.read) begin
                    rd_addr_d  = bus.read_addrs;
                    rd_cnt_d   = wait_q;
                    rd_state_d = (wait_q == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                rd_cnt_d = rd_cnt_q - 4'd1;
                if (rd_cnt_q <= 4'd1) begin
                    rd_state_d = S_RESP;
                end
            end
            S_RESP:  rd_state_d = S_IDLE;
            default: rd_state_d = S_IDLE;
        endcase
    end

    assign w_rd_fire = (rd_state_d == S_RESP) && (rd_state_q != S_RESP);
    assign w_rd_idx  = rd_addr_d[GP_ADDR_WIDTH-1:2];
    assign w_rd_err  = (rd_addr_d[1:0] != 2'b00) || (w_rd_idx > c_IDX_ERRCNT);

    // Read mux sees the pre-update register values, so a write committing
    // on the same edge is not visible to this read.
    always_comb begin
        w_rd_val = '0;
        case (w_rd_idx)
            c_IDX_ID:     w_rd_val = DATA_WIDTH'(ID_VALUE);
            c_IDX_SCR0:   w_rd_val = scratch0_q;
            c_IDX_SCR1:   w_rd_val = scratch1_q;
            c_IDX_CTRL:   w_rd_val = DATA_WIDTH'({wait_q, 3'b000, en_q});
            c_IDX_COUNT:  w_rd_val = DATA_WIDTH'(count_q);
            c_IDX_ERRCNT: w_rd_val = DATA_WIDTH'(errcnt_q);
            default:      w_rd_val = '0;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (rst) begin
            rd_state_q <= S_IDLE;
            rd_cnt_q   <= 4'd0;
            rd_addr_q  <= '0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_err_q   <= w_rd_fire && w_rd_err;
            rd_data_q  <= (w_rd_fire && !w_rd_err) ? w_rd_val : '0;
        end
    end

    // ------------------------------------------------------------------
    // Register updates
    // ------------------------------------------------------------------
    logic        w_clr;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_clr     = w_wr_commit && (w_wr_idx == c_IDX_CTRL) &&
                       wr_strb_d[0] && wr_data_d[1];
    assign w_err_inc = {1'b0, w_wr_fire && w_wr_err} + {1'b0, w_rd_fire && w_rd_err};
    assign w_err_sum = {1'b0, errcnt_q} + {15'd0, w_err_inc};

    always_ff @(posedge s_axi_aclk) begin
        if (rst) begin
            scratch0_q <= '0;
            scratch1_q <= '0;
            en_q       <= 1'b0;
            wait_q     <= RESET_WAIT;
            count_q    <= 32'd0;
            errcnt_q   <= 16'd0;
        end else begin
            if (w_wr_commit) begin
                case (w_wr_idx)
                    c_IDX_SCR0: scratch0_q <= f_merge(scratch0_q, wr_data_d, wr_strb_d);
                    c_IDX_SCR1: scratch1_q <= f_merge(scratch1_q, wr_data_d, wr_strb_d);
                    c_IDX_CTRL: begin
                        if (wr_strb_d[0]) begin
                            en_q   <= wr_data_d[0];
                            wait_q <= wr_data_d[7:4];
                        end
                    end
                    default: ;
                endcase
            end

            // CLR wins over the increment; a new EN takes effect next cycle.
            if (w_clr) begin
                count_q <= 32'd0;
            end else if (en_q) begin
                count_q <= count_q + 32'd1;
            end

            errcnt_q <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.write_done  = (wr_state_q == S_RESP);
    assign bus.write_error = wr_err_q;
    assign bus.read_done   = (rd_state_q == S_RESP);
    assign bus.read_error  = rd_err_q;
    assign bus.read_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_gp_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_reg_bank
// Description : Self-checking bench for gp_reg_bank with randomized data,
//               strobes and wait states against a behavioural register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gp_reg_bank;

    localparam int          AW = 6;
    localparam int          DW = 32;
    localparam logic [31:0] ID = 32'hA11E0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gp_reg_bank_if #(.GP_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    gp_reg_bank #(
        .GP_ADDR_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .ID_VALUE     (ID),
        .RESET_WAIT   (4'd0)
    ) dut (
        .s_axi_aclk(clk),
        .rst       (rst),
        .bus       (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned edge_no = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    // ------------------------------------------------------------------
    // Reference model: register values plus a COUNT expressed as a base
    // value and the edge it was established at.
    // ------------------------------------------------------------------
    logic [31:0] m_s0, m_s1, m_cbase;
    logic        m_en;
    logic [3:0]  m_wait;
    logic [15:0] m_errcnt;
    int unsigned m_cedge;

    function automatic bit m_is_err(input logic [5:0] a, input bit is_wr);
        int w;
        w = int'(a[5:2]);
        if (a[1:0] != 2'b00) return 1'b1;
        if (w > 5) return 1'b1;
        if (is_wr && (w == 0 || w == 4 || w == 5)) return 1'b1;
        return 1'b0;
    endfunction

    // COUNT value just before edge e
    function automatic logic [31:0] m_count_at(input int unsigned e);
        return m_en ? (m_cbase + (e - 1 - m_cedge)) : m_cbase;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a, input int unsigned e);
        if (m_is_err(a, 1'b0)) return 32'd0;
        case (a[5:2])
            4'd0:    return ID;
            4'd1:    return m_s0;
            4'd2:    return m_s1;
            4'd3:    return {24'd0, m_wait, 3'b000, m_en};
            4'd4:    return m_count_at(e);
            default: return {16'd0, m_errcnt};
        endcase
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    task automatic m_err_bump();
        if (m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
    endtask

    task automatic m_reset();
        m_s0 = 0; m_s1 = 0; m_en = 0; m_wait = 4'd0; m_errcnt = 0;
        m_cbase = 0; m_cedge = edge_no;
    endtask

    task automatic m_apply_write(input logic [5:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int unsigned e);
        logic [31:0] v;
        if (m_is_err(a, 1'b1)) begin
            m_err_bump();
        end else begin
            case (a[5:2])
                4'd1: m_s0 = m_merge(m_s0, d, s);
                4'd2: m_s1 = m_merge(m_s1, d, s);
                4'd3: begin
                    if (s[0]) begin
                        v = m_count_at(e) + (m_en ? 32'd1 : 32'd0);
                        if (d[1]) v = 32'd0;
                        m_cbase = v;
                        m_cedge = e;
                        m_en    = d[0];
                        m_wait  = d[7:4];
                    end
                end
                default: ;
            endcase
        end
    endtask

    // ------------------------------------------------------------------
    // Bus access tasks
    // ------------------------------------------------------------------
    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            output bit err, output bit exp_err, output int lat);
        @(negedge clk);
        bus.write = 1'b1; bus.write_addrs = a; bus.write_data = d; bus.write_strobe = s;
        lat = 0; err = 1'b0; exp_err = m_is_err(a, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.write_done === 1'b1) break;
        end
        total++;
        if (bus.write_done !== 1'b1) begin
            bad++;
            $display("FAIL write_timeout addr=%h: got write_done=%b want 1", a, bus.write_done);
        end else begin
            err = bus.write_error;
            m_apply_write(a, d, s, edge_no);
        end
        bus.write = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [31:0] exp,
                           output bit err, output bit exp_err, output int lat);
        @(negedge clk);
        bus.read = 1'b1; bus.read_addrs = a;
        lat = 0; err = 1'b0; d = 32'd0; exp = 32'd0; exp_err = m_is_err(a, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.read_done === 1'b1) break;
        end
        total++;
        if (bus.read_done !== 1'b1) begin
            bad++;
            $display("FAIL read_timeout addr=%h: got read_done=%b want 1", a, bus.read_done);
        end else begin
            d   = bus.read_data;
            err = bus.read_error;
            exp = m_read(a, edge_no);
            if (exp_err) m_err_bump();
        end
        bus.read = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    logic [31:0] d, exp, d1;
    bit          err, exp_err;
    int          lat;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.write_done, bus.write_error, bus.read_done, bus.read_error, bus.read_data} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs: got wd=%b we=%b rd=%b re=%b data=%h want all 0",
                     bus.write_done, bus.write_error, bus.read_done, bus.read_error, bus.read_data);
        end
        rst = 1'b0;
        m_reset();
        do_read(6'h00, d, exp, err, exp_err, lat);
        total++;
        if (d !== ID || err !== 1'b0 || lat !== 1) begin
            bad++;
            $display("FAIL reset_id_read: got data=%h err=%b lat=%0d want %h 0 1", d, err, lat, ID);
        end
        do_write(6'h04, 32'h12345678, 4'hF, err, exp_err, lat);
        total++;
        if (err !== 1'b0 || lat !== 1) begin
            bad++;
            $display("FAIL scratch0_write: got err=%b lat=%0d want 0 1", err, lat);
        end
        do_read(6'h04, d, exp, err, exp_err, lat);
        total++;
        if (d !== 32'h12345678 || d !== exp) begin
            bad++;
            $display("FAIL scratch0_read: got %h want %h", d, exp);
        end
    endtask

    task automatic test_strobes();
        logic [5:0]  a;
        logic [31:0] wd;
        logic [3:0]  s;
        do_write(6'h08, 32'hDEADBEEF, 4'hF, err, exp_err, lat);
        do_write(6'h08, 32'h00000000, 4'h5, err, exp_err, lat);
        do_read(6'h08, d, exp, err, exp_err, lat);
        total++;
        if (d !== 32'hDE00BE00 || d !== exp) begin
            bad++;
            $display("FAIL strobe_0x5: got %h want DE00BE00 (model %h)", d, exp);
        end
        do_write(6'h08, $urandom, 4'h0, err, exp_err, lat);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL strobe_zero_err: got %b want 0", err);
        end
        do_read(6'h08, d, exp, err, exp_err, lat);
        total++;
        if (d !== 32'hDE00BE00) begin
            bad++;
            $display("FAIL strobe_zero_data: got %h want DE00BE00", d);
        end
        for (int i = 0; i < 8; i++) begin
            a  = 6'($urandom_range(1, 2) * 4);
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            do_write(a, wd, s, err, exp_err, lat);
            do_read(a, d, exp, err, exp_err, lat);
            total++;
            if (d !== exp || err !== 1'b0) begin
                bad++;
                $display("FAIL rand_strobe[%0d] addr=%h strb=%h: got %h err=%b want %h 0",
                         i, a, s, d, err, exp);
            end
        end
    endtask

    task automatic test_wait_states();
        int unsigned w;
        int          old_w;
        int          gap;
        do_write(6'h0C, 32'h21, 4'h1, err, exp_err, lat);
        do_read(6'h04, d, exp, err, exp_err, lat);
        total++;
        if (lat !== 3 || d !== exp) begin
            bad++;
            $display("FAIL wait2_read: got lat=%0d data=%h want 3 %h", lat, d, exp);
        end
        do_read(6'h10, d1, exp, err, exp_err, lat);
        total++;
        if (d1 !== exp) begin
            bad++;
            $display("FAIL count_first: got %h want %h", d1, exp);
        end
        // Same read latency both times, so start 10 cycles later: capture 10 apart.
        repeat (10 - 4) @(negedge clk);
        do_read(6'h10, d, exp, err, exp_err, lat);
        total++;
        if (d !== exp || (d - d1) !== 32'd10) begin
            bad++;
            $display("FAIL count_delta: got %h (delta %0d) want %h (delta 10)", d, d - d1, exp);
        end
        do_write(6'h0C, 32'h23, 4'h1, err, exp_err, lat);
        do_read(6'h10, d, exp, err, exp_err, lat);
        total++;
        if (d !== exp || d > 32'd8) begin
            bad++;
            $display("FAIL count_clear: got %h want %h", d, exp);
        end
        do_read(6'h0C, d, exp, err, exp_err, lat);
        total++;
        if (d !== exp || d[1] !== 1'b0) begin
            bad++;
            $display("FAIL ctrl_clr_reads0: got %h want %h", d, exp);
        end
        for (int i = 0; i < 5; i++) begin
            w     = $urandom_range(0, 6);
            old_w = int'(m_wait);
            do_write(6'h0C, {24'd0, 4'(w), 4'b0001}, 4'h1, err, exp_err, lat);
            total++;
            if (lat !== old_w + 1) begin
                bad++;
                $display("FAIL wait_write_lat[%0d]: got %0d want %0d", i, lat, old_w + 1);
            end
            do_read(6'h08, d, exp, err, exp_err, lat);
            gap = int'(w) + 1;
            total++;
            if (lat !== gap || d !== exp) begin
                bad++;
                $display("FAIL wait_read_lat[%0d]: got lat=%0d data=%h want %0d %h", i, lat, d, gap, exp);
            end
        end
        do_write(6'h0C, 32'h01, 4'h1, err, exp_err, lat);
    endtask

    task automatic test_errors();
        logic [5:0] a;
        bit         e2;
        do_write(6'h10, $urandom, 4'hF, err, exp_err, lat);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_write_count: got %b want 1", err);
        end
        do_write(6'h06, $urandom, 4'hF, err, exp_err, lat);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_write_misaligned: got %b want 1", err);
        end
        do_read(6'h20, d, exp, err, exp_err, lat);
        total++;
        if (err !== 1'b1 || d !== 32'd0) begin
            bad++; $display("FAIL err_read_unmapped: got err=%b data=%h want 1 0", err, d);
        end
        do_read(6'h04, d, exp, err, exp_err, lat);
        total++;
        if (d !== exp) begin
            bad++; $display("FAIL err_no_change: got %h want %h", d, exp);
        end
        do_read(6'h14, d, exp, err, exp_err, lat);
        total++;
        if (d !== 32'd3 || d !== exp) begin
            bad++; $display("FAIL errcnt_3: got %h want 3", d);
        end
        for (int i = 0; i < 6; i++) begin
            a = 6'($urandom_range(0, 63));
            do_write(a, $urandom, 4'hF, err, exp_err, lat);
            do_read(a, d, exp, e2, exp_err, lat);
            total++;
            if (err !== m_is_err(a, 1'b1) || e2 !== exp_err || d !== exp) begin
                bad++;
                $display("FAIL rand_err[%0d] addr=%h: got werr=%b rerr=%b data=%h want %b %b %h",
                         i, a, err, e2, d, m_is_err(a, 1'b1), exp_err, exp);
            end
        end
        do_read(6'h14, d, exp, err, exp_err, lat);
        total++;
        if (d !== exp) begin
            bad++; $display("FAIL errcnt_rand: got %h want %h", d, exp);
        end
    endtask

    task automatic do_both(input logic [5:0] wa, input logic [31:0] wd, input logic [5:0] ra,
                           output bit werr, output bit rerr, output logic [31:0] rdata,
                           output logic [31:0] rexp, output int wlat, output int rlat);
        bit          wdn, rdn;
        int unsigned we, re;
        wdn = 0; rdn = 0; wlat = 0; rlat = 0; werr = 0; rerr = 0; rdata = 0; rexp = 0;
        we = 0; re = 0;
        @(negedge clk);
        bus.write = 1'b1; bus.write_addrs = wa; bus.write_data = wd; bus.write_strobe = 4'hF;
        bus.read  = 1'b1; bus.read_addrs  = ra;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!wdn && bus.write_done === 1'b1) begin
                wdn = 1; wlat = i; werr = bus.write_error; we = edge_no; bus.write = 1'b0;
            end
            if (!rdn && bus.read_done === 1'b1) begin
                rdn = 1; rlat = i; rerr = bus.read_error; rdata = bus.read_data; re = edge_no;
                bus.read = 1'b0;
            end
            if (wdn && rdn) break;
        end
        bus.write = 1'b0; bus.read = 1'b0;
        total++;
        if (!(wdn && rdn)) begin
            bad++;
            $display("FAIL both_timeout: got wdone=%b rdone=%b want 1 1", wdn, rdn);
        end else begin
            if (we < re) m_apply_write(wa, wd, 4'hF, we);
            rexp = m_read(ra, re);
            if (m_is_err(ra, 1'b0)) m_err_bump();
            if (we >= re) m_apply_write(wa, wd, 4'hF, we);
        end
    endtask

    task automatic test_simultaneous();
        bit          werr, rerr;
        logic [31:0] rdata, rexp, ec;
        int          wlat, rlat;
        do_write(6'h08, 32'h0, 4'hF, err, exp_err, lat);
        do_both(6'h08, 32'hE11E, 6'h08, werr, rerr, rdata, rexp, wlat, rlat);
        total++;
        if (wlat !== rlat || rdata !== 32'h0 || rdata !== rexp || werr || rerr) begin
            bad++;
            $display("FAIL simul_rw: got wlat=%0d rlat=%0d data=%h want same lat data 0", wlat, rlat, rdata);
        end
        do_read(6'h08, d, exp, err, exp_err, lat);
        total++;
        if (d !== 32'hE11E || d !== exp) begin
            bad++; $display("FAIL simul_after: got %h want 0000E11E", d);
        end
        do_read(6'h14, ec, exp, err, exp_err, lat);
        do_both(6'h00, $urandom, 6'h3C, werr, rerr, rdata, rexp, wlat, rlat);
        total++;
        if (!werr || !rerr || wlat !== rlat) begin
            bad++; $display("FAIL simul_err: got werr=%b rerr=%b want 1 1", werr, rerr);
        end
        do_read(6'h14, d, exp, err, exp_err, lat);
        total++;
        if (d !== ec + 32'd2 || d !== exp) begin
            bad++; $display("FAIL errcnt_plus2: got %h want %h", d, ec + 32'd2);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        do_write(6'h0C, 32'h30, 4'h1, err, exp_err, lat);
        @(negedge clk);
        bus.write = 1'b1; bus.write_addrs = 6'h04; bus.write_data = $urandom | 32'h1;
        bus.write_strobe = 4'hF;
        repeat (2) begin
            @(negedge clk);
            if (bus.write_done === 1'b1) seen++;
        end
        rst = 1'b1; bus.write = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.write_done === 1'b1) seen++;
        end
        // Hold a read request through reset; it must be served after release.
        bus.read = 1'b1; bus.read_addrs = 6'h00;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (4) begin
            if (bus.write_done === 1'b1) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rst_mid_done: got %0d done pulses want 0", seen);
        end
        bus.read = 1'b0;
        do_read(6'h04, d, exp, err, exp_err, lat);
        total++;
        if (d !== 32'd0 || d !== exp) begin
            bad++; $display("FAIL rst_mid_scratch: got %h want 0", d);
        end
        do_read(6'h0C, d, exp, err, exp_err, lat);
        total++;
        if (d !== 32'd0 || lat !== 1) begin
            bad++; $display("FAIL rst_mid_ctrl: got %h lat=%0d want 0 1", d, lat);
        end
    endtask

    task automatic test_held_request();
        int got;
        got = 0;
        rst = 1'b1;
        @(negedge clk);
        bus.read = 1'b1; bus.read_addrs = 6'h00;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        if (bus.read_done === 1'b1 && bus.read_data === ID) got = 1;
        bus.read = 1'b0;
        total++;
        if (got !== 1) begin
            bad++;
            $display("FAIL held_req: got done=%b data=%h want 1 %h", bus.read_done, bus.read_data, ID);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.write = 1'b0; bus.write_addrs = '0; bus.write_data = '0; bus.write_strobe = '0;
        bus.read  = 1'b0; bus.read_addrs  = '0;
        m_reset();
        test_reset();
        test_strobes();
        test_wait_states();
        test_errors();
        test_simultaneous();
        test_reset_mid();
        test_held_request();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gp_reg_bank.md
Name: gp_reg_bank

Overview:
Register bank that consumes the general-purpose (GP) read/write interface produced by the AXI-Lite slave. It decodes word addresses and applies byte strobes to writes. It answers each access with done/error after a programmable number of wait states. Contents: ID, two scratch words, control, a free-running counter and an error counter. Read and write channels are served independently and may complete in the same cycle.

Parameters:
GP_ADDR_WIDTH, 6, byte address width of the GP interface (16 word slots)
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
ID_VALUE, 32'hA11E0001, constant returned at offset 0x00
RESET_WAIT, 4'd0, reset value of CTRL.WAIT

Ports:
s_axi_aclk  in  1  clock, shared with the AXI-Lite slave
rst  in  1  synchronous active-high reset
write  in  1  write request, held high until write_done is sampled
write_addrs  in  GP_ADDR_WIDTH  write byte address
write_data  in  DATA_WIDTH  write data
write_strobe  in  DATA_WIDTH/8  byte enables
write_done  out  1  one-cycle write completion pulse
write_error  out  1  valid with write_done; 1 = access rejected
read  in  1  read request, held high until read_done is sampled
read_addrs  in  GP_ADDR_WIDTH  read byte address
read_data  out  DATA_WIDTH  read data, valid while read_done=1, else 0
read_done  out  1  one-cycle read completion pulse
read_error  out  1  valid with read_done

Behaviour:
- Register map (word offsets):
  - 0x00 ID: RO, ID_VALUE.
  - 0x04 SCRATCH0: RW, reset 0.
  - 0x08 SCRATCH1: RW, reset 0.
  - 0x0C CTRL: RW. bit0 EN (reset 0). bit1 CLR (write-1 pulse, reads 0). bits[7:4] WAIT (reset RESET_WAIT). Other bits read 0.
  - 0x10 COUNT: RO, 32-bit.
  - 0x14 ERRCNT: RO, 16-bit zero-extended.
  - 0x18–0x3C: unmapped.
- Error conditions, per channel:
  - Address bits [1:0] != 0.
  - Unmapped offset.
  - Write to a RO offset.
  - An errored write modifies nothing. An errored read returns read_data=0.
- Per-channel FSM: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: request high at an edge -> latch address, data and strobe. Latch the current CTRL.WAIT into a down-counter. Go to WAIT, or straight to RESP if WAIT=0.
  - WAIT: decrement each cycle. At 0, go to RESP.
  - RESP: done=1 for exactly one cycle; error valid. Next state IDLE.
  - Request high again in IDLE is a new access. The requester deasserts the cycle after done.
- Latency: done asserts WAIT+1 cycles after the first cycle the request is high. WAIT=0 gives 1-cycle latency.
- Write commit: at the same edge that raises write_done. Only bytes with strobe=1 change. Strobe=0 is a legal, non-error no-op.
- Read capture: at the same edge that raises read_done. If a write to the same register commits at that edge, the read returns the pre-write value.
- CTRL.WAIT changes take effect for accesses accepted after the commit edge.
- COUNT behaviour:
  - Increments by 1 per cycle while EN=1; wraps 0xFFFFFFFF -> 0.
  - CLR write clears COUNT to 0 at the commit edge, with priority over increment.
  - EN and CLR in the same write: COUNT=0 at commit, then counts from the next cycle.
- ERRCNT: +1 per errored completion, +2 if both channels complete with error on the same edge. Saturates at 0xFFFF; cleared only by rst.
- Reset:
  - All outputs 0; both FSMs to IDLE; registers to reset values.
  - rst mid-access aborts the access with no done pulse and no commit.
  - A request still high after rst falls is accepted as a new access.

Test Plan:
- Reset, WAIT=0: read 0x00 -> read_done one cycle after request, read_data=0xA11E0001, read_error=0. Write 0x04=0x12345678 strobe 0xF, then read -> 0x12345678.
- Byte strobes: SCRATCH1=0xDEADBEEF, then write 0x00000000 strobe 0x5 -> read 0xDE00BE00. Strobe 0x0 -> unchanged, write_error=0.
- Wait states: write CTRL=0x21 (WAIT=2, EN=1). Next read -> read_done exactly 3 cycles after request. COUNT read twice 10 cycles apart differs by 10. Write CTRL bit1 -> next COUNT read small and CTRL bit1 reads 0.
- Errors: write 0x10, write 0x06, read 0x20 -> each done with error=1, read_data=0, no state change. ERRCNT reads 3.
- Simultaneous: write 0x08=0xE11E and read 0x08 (old 0x0) issued together -> both done same cycle, read returns 0x0, a later read returns 0xE11E. Both channels erroring together -> ERRCNT +2.
- Reset mid-access with WAIT=3: assert rst in the WAIT state -> no done pulse, the target register keeps its reset value, CTRL.WAIT=RESET_WAIT.
